tiro_nave: RTL and testbench
============================

Name: tiro_nave

Overview:
Player-ship projectile controller for the invaders game. Launches one shot per fire-button press from the ship's current position and moves it upward on a divided movement tick. It drives x_bola_nave/y_bola_nave, which feed every enemy's collision check. It retires the shot on an enemy-hit pulse or at the top of the screen, and keeps a saturating hit score.

Parameters:
DIV_MAX, 80000, CLOCK_50 cycles per movement tick (use 4 in simulation)
VEL, 4, pixels moved upward per tick
OFFSET_X, 16, horizontal offset from ship left edge to muzzle
Y_TOPO, 8, shot retires when y would drop below this
COOLDOWN, 10, ticks after retirement before a new shot is accepted

Ports:
CLOCK_50  input  1  system clock, 50 MHz
reset  input  1  asynchronous reset, active-low (asserted at 0)
reiniciarJogo  input  1  synchronous game restart, active-high; same effect as reset
pausa  input  1  1 = freeze movement, tick divider and fire acceptance
disparo  input  1  raw fire button, active-high, asynchronous to clock
x_nave  input  10  ship left-edge x
y_nave  input  10  ship top-edge y
acerto  input  1  enemy-hit pulse (OR of enemy kill events), 1+ cycles
x_bola_nave  output  10  shot x; 0 when no shot in flight
y_bola_nave  output  10  shot y; 0 when no shot in flight
ativo  output  1  1 while shot in flight
pontos  output  8  hit count, saturates at 255

Behaviour:
- Reset (reset=0, async) or reiniciarJogo=1 (next edge): state IDLE, x/y=0, ativo=0, pontos=0, cooldown=0, divider=0, sync/edge regs cleared. reiniciarJogo has priority over every other event.
- Parked position (0,0) never satisfies an enemy's strict-inequality collision test.
- Divider: counts 0..DIV_MAX-1 while pausa=0, then wraps. tick=1 for exactly one cycle at count DIV_MAX-1. Count holds while pausa=1.
- Fire input: disparo passes through a 2-FF synchronizer. fire_edge = sync rising edge, a 1-cycle pulse. The edge is never queued: a press ignored because of state, cooldown or pausa is lost.
- Launch x = x_nave + OFFSET_X in 11 bits, clamped to 639. Launch y = y_nave.
- FSM:
  - IDLE: ativo=0, outputs parked. tick with cooldown>0 -> cooldown-1. fire_edge with cooldown=0 and pausa=0 -> load launch x/y, go VOO. Outputs valid the next cycle.
  - VOO: ativo=1. acerto=1 (honoured even during pausa) -> ACERTO. Otherwise tick: if y < Y_TOPO+VEL -> park, cooldown=COOLDOWN, go IDLE (miss); else y = y-VEL. x stays constant in flight.
  - ACERTO (one cycle): park, ativo=0, pontos+1 unless already 255, cooldown=COOLDOWN, go IDLE.
- Simultaneous events: acerto with a top-retire tick -> hit wins. acerto in IDLE/ACERTO -> ignored (no double score). fire_edge during VOO -> ignored.
- Latency: fire_edge -> ativo=1 one cycle. acerto -> ativo=0 two cycles, with pontos updated in the same cycle ativo falls.
- y is 10-bit unsigned. The retire compare prevents underflow wrap.

Test Plan:
- DIV_MAX=4, x_nave=100, y_nave=440, press disparo -> ativo=1 within 4 cycles of the press, x=116, y=440. After 3 ticks y=428.
- Hold flight to the top (VEL=4, Y_TOPO=8) -> last y=8, then parked (0,0), ativo=0, pontos unchanged. A press during the 10-tick cooldown is ignored. A press after cooldown launches.
- Pulse acerto for 3 cycles mid-flight -> ativo=0 two cycles after the first acerto cycle, pontos=1 (not 3), outputs (0,0).
- x_nave=630 launch -> x_bola_nave=639. Assert pausa mid-flight -> y frozen for 100 cycles. A press during pausa produces no new shot. Release -> motion resumes.
- reset=0 asynchronously mid-flight (no clock edge) -> immediate ativo=0, (0,0), pontos=0. reiniciarJogo with fire_edge in the same cycle -> stays IDLE.
- 256 hits -> pontos=255 and holds.

Source files
------------

// File: rtl/tiro_nave.sv
// ---------------------------------------------------------------------------
// tiro_nave
// Player-ship projectile controller. A fire-button press launches one shot
// from the ship's muzzle. The shot then climbs VEL pixels on every movement
// tick until it either hits an enemy or reaches the top of the screen. While
// no shot is in flight the position outputs are parked at (0,0). Every hit
// adds one to a score that saturates at 255.
//
// Ports:
//   CLOCK_50       in   1   system clock
//   reset          in   1   asynchronous reset, active-low
//   reiniciarJogo  in   1   synchronous game restart, active-high (same as reset)
//   pausa          in   1   freezes movement, the tick divider and fire acceptance
//   disparo        in   1   raw fire button, asynchronous to CLOCK_50
//   x_nave         in  10   ship left-edge x
//   y_nave         in  10   ship top-edge y
//   acerto         in   1   enemy-hit pulse, one or more cycles long
//   x_bola_nave    out 10   shot x (0 when idle)
//   y_bola_nave    out 10   shot y (0 when idle)
//   ativo          out  1   shot in flight
//   pontos         out  8   saturating hit count
// ---------------------------------------------------------------------------
module tiro_nave #(
  parameter int DIV_MAX  = 80000,
  parameter int VEL      = 4,
  parameter int OFFSET_X = 16,
  parameter int Y_TOPO   = 8,
  parameter int COOLDOWN = 10
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       reiniciarJogo,
  input  logic       pausa,
  input  logic       disparo,
  input  logic [9:0] x_nave,
  input  logic [9:0] y_nave,
  input  logic       acerto,
  output logic [9:0] x_bola_nave,
  output logic [9:0] y_bola_nave,
  output logic       ativo,
  output logic [7:0] pontos
);

  localparam int DIV_W = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV_MAX - 1);
  localparam logic [9:0]       Y_LIMITE   = 10'(Y_TOPO + VEL);
  localparam logic [9:0]       VEL_V      = 10'(VEL);
  localparam logic [10:0]      OFFSET_V   = 11'(OFFSET_X);
  localparam logic [10:0]      X_MAX      = 11'd639;
  localparam logic [CD_W-1:0]  COOLDOWN_V = CD_W'(COOLDOWN);

  typedef enum logic [1:0] {
    IDLE,
    VOO,
    ACERTO
  } estado_t;

  estado_t          estado_q, estado_d;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             sync1, sync2, sync_prev;
  logic             fire_edge;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             ativo_q, ativo_d;
  logic [CD_W-1:0]  cd_q, cd_d;
  logic [7:0]       pontos_q, pontos_d;
  logic [10:0]      x_soma;
  logic [9:0]       x_lanc;

  // Movement tick divider. The count holds while paused, and the tick is also
  // gated by pausa so a pause landing on the last count cannot stretch the
  // tick pulse into several cycles.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (reiniciarJogo) begin
      div_cnt <= '0;
    end else if (!pausa) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    end
  end

  assign tick = !pausa && (div_cnt == DIV_LAST);

  // Two-flop synchronizer on the fire button, followed by a history flop that
  // turns the synchronized level into a one-cycle rising-edge pulse.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else if (reiniciarJogo) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= disparo;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign fire_edge = sync2 && !sync_prev;

  // Muzzle position is computed in 11 bits so a ship near the right edge
  // clamps to the last visible column instead of wrapping to the left.
  assign x_soma = {1'b0, x_nave} + OFFSET_V;
  assign x_lanc = (x_soma > X_MAX) ? X_MAX[9:0] : x_soma[9:0];

  // State and datapath registers. The restart input overrides everything
  // else, including a fire edge or hit arriving in the same cycle.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      estado_q <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      ativo_q  <= 1'b0;
      cd_q     <= '0;
      pontos_q <= '0;
    end else if (reiniciarJogo) begin
      estado_q <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      ativo_q  <= 1'b0;
      cd_q     <= '0;
      pontos_q <= '0;
    end else begin
      estado_q <= estado_d;
      x_q      <= x_d;
      y_q      <= y_d;
      ativo_q  <= ativo_d;
      cd_q     <= cd_d;
      pontos_q <= pontos_d;
    end
  end

  // Next-state logic. A hit is checked before the movement tick, so a hit and
  // a top-of-screen retirement in the same cycle count as a hit. The miss
  // compare runs before the subtraction, so y never wraps below zero. The
  // ACERTO state holds the outputs for one extra cycle; the score update and
  // the fall of ativo then happen together on the way back to IDLE.
  always_comb begin
    estado_d = estado_q;
    x_d      = x_q;
    y_d      = y_q;
    ativo_d  = ativo_q;
    cd_d     = cd_q;
    pontos_d = pontos_q;
    case (estado_q)
      IDLE: begin
        if (fire_edge && (cd_q == '0) && !pausa) begin
          x_d      = x_lanc;
          y_d      = y_nave;
          ativo_d  = 1'b1;
          estado_d = VOO;
        end else if (tick && (cd_q != '0)) begin
          cd_d = cd_q - CD_W'(1);
        end
      end
      VOO: begin
        if (acerto) begin
          estado_d = ACERTO;
        end else if (tick) begin
          if (y_q < Y_LIMITE) begin
            x_d      = '0;
            y_d      = '0;
            ativo_d  = 1'b0;
            cd_d     = COOLDOWN_V;
            estado_d = IDLE;
          end else begin
            y_d = y_q - VEL_V;
          end
        end
      end
      ACERTO: begin
        x_d      = '0;
        y_d      = '0;
        ativo_d  = 1'b0;
        cd_d     = COOLDOWN_V;
        pontos_d = (pontos_q == 8'd255) ? pontos_q : pontos_q + 8'd1;
        estado_d = IDLE;
      end
      default: begin
        estado_d = IDLE;
      end
    endcase
  end

  assign x_bola_nave = x_q;
  assign y_bola_nave = y_q;
  assign ativo       = ativo_q;
  assign pontos      = pontos_q;

endmodule

// File: tb/tb_tiro_nave.sv
// ---------------------------------------------------------------------------
// tb_tiro_nave
// Directed bench for tiro_nave with a 4-cycle movement tick. Expected values
// are worked out by hand from the launch point (100,440) with VEL=4:
// any 4*k consecutive unpaused clock edges contain exactly k ticks.
// ---------------------------------------------------------------------------
module tb_tiro_nave;

  logic       CLOCK_50;
  logic       reset;
  logic       reiniciarJogo;
  logic       pausa;
  logic       disparo;
  logic [9:0] x_nave;
  logic [9:0] y_nave;
  logic       acerto;
  logic [9:0] x_bola_nave;
  logic [9:0] y_bola_nave;
  logic       ativo;
  logic [7:0] pontos;

  int check_count = 0;
  int fail_count  = 0;

  tiro_nave #(
    .DIV_MAX (4),
    .VEL     (4),
    .OFFSET_X(16),
    .Y_TOPO  (8),
    .COOLDOWN(10)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .reiniciarJogo(reiniciarJogo),
    .pausa        (pausa),
    .disparo      (disparo),
    .x_nave       (x_nave),
    .y_nave       (y_nave),
    .acerto       (acerto),
    .x_bola_nave  (x_bola_nave),
    .y_bola_nave  (y_bola_nave),
    .ativo        (ativo),
    .pontos       (pontos)
  );

  // 100 MHz simulation clock; the period only matters relative to itself.
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Counts one comparison and reports it when the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drives the three per-cycle control inputs together.
  task automatic applyStimulus(input logic fire, input logic hit, input logic pause);
    disparo = fire;
    acerto  = hit;
    pausa   = pause;
  endtask

  // Advances n rising edges and leaves the bench 1 time unit after the last.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  // Waits a bounded number of edges for a shot to become active.
  task automatic wait_launch(input int max_cycles, input string tag);
    int n;
    n = 0;
    do begin
      step(1);
      n++;
    end while (!ativo && n < max_cycles);
    checkOutput(tag, ativo, 1);
  endtask

  initial begin
    logic [9:0] last_y;
    int         n;
    int         launch_misses;
    logic [7:0] pontos_at_255;

    reset         = 1'b0;
    reiniciarJogo = 1'b0;
    x_nave        = 10'd100;
    y_nave        = 10'd440;
    applyStimulus(0, 0, 0);
    #12;
    checkOutput("reset_ativo", ativo, 0);
    checkOutput("reset_x", x_bola_nave, 0);
    checkOutput("reset_y", y_bola_nave, 0);
    checkOutput("reset_pontos", pontos, 0);
    reset = 1'b1;
    step(2);

    // Launch from (100,440): muzzle at x=116, then three ticks -> y=428.
    applyStimulus(1, 0, 0);
    wait_launch(4, "launch_latency");
    applyStimulus(0, 0, 0);
    checkOutput("launch_x", x_bola_nave, 116);
    checkOutput("launch_y", y_bola_nave, 440);
    step(12);
    checkOutput("three_ticks_y", y_bola_nave, 428);
    checkOutput("three_ticks_x", x_bola_nave, 116);

    // Fly to the top: the last in-flight y must be 8, then park as a miss.
    last_y = y_bola_nave;
    n = 0;
    while (ativo && n < 600) begin
      last_y = y_bola_nave;
      step(1);
      n++;
    end
    checkOutput("top_retired", ativo, 0);
    checkOutput("top_last_y", last_y, 8);
    checkOutput("top_park_x", x_bola_nave, 0);
    checkOutput("top_park_y", y_bola_nave, 0);
    checkOutput("top_pontos", pontos, 0);

    // A press during the cooldown is dropped and never replayed later.
    applyStimulus(1, 0, 0);
    step(8);
    checkOutput("cooldown_press_ignored", ativo, 0);
    applyStimulus(0, 0, 0);
    step(45);
    checkOutput("cooldown_press_not_queued", ativo, 0);
    applyStimulus(1, 0, 0);
    wait_launch(4, "launch_after_cooldown");
    applyStimulus(0, 0, 0);
    checkOutput("relaunch_x", x_bola_nave, 116);
    checkOutput("relaunch_y", y_bola_nave, 440);

    // Three-cycle hit pulse: ativo falls on the second edge, one point only.
    step(5);
    applyStimulus(0, 1, 0);
    step(1);
    checkOutput("hit_ativo_after_1", ativo, 1);
    step(1);
    checkOutput("hit_ativo_after_2", ativo, 0);
    checkOutput("hit_pontos_after_2", pontos, 1);
    step(1);
    applyStimulus(0, 0, 0);
    step(2);
    checkOutput("hit_pontos_single", pontos, 1);
    checkOutput("hit_park_x", x_bola_nave, 0);
    checkOutput("hit_park_y", y_bola_nave, 0);

    // Right-edge launch clamps to 639; pausa freezes y and swallows a press.
    x_nave = 10'd630;
    step(45);
    applyStimulus(1, 0, 0);
    wait_launch(4, "launch_clamp");
    applyStimulus(0, 0, 0);
    checkOutput("clamp_x", x_bola_nave, 639);
    step(8);
    checkOutput("pre_pause_y", y_bola_nave, 432);
    applyStimulus(0, 0, 1);
    step(50);
    applyStimulus(1, 0, 1);
    step(10);
    applyStimulus(0, 0, 1);
    step(40);
    checkOutput("pause_y_frozen", y_bola_nave, 432);
    checkOutput("pause_ativo", ativo, 1);
    applyStimulus(0, 0, 0);
    step(12);
    checkOutput("resume_y", y_bola_nave, 420);
    checkOutput("resume_x", x_bola_nave, 639);

    // Asynchronous reset between clock edges clears everything at once.
    reset = 1'b0;
    #2;
    checkOutput("async_ativo", ativo, 0);
    checkOutput("async_x", x_bola_nave, 0);
    checkOutput("async_y", y_bola_nave, 0);
    checkOutput("async_pontos", pontos, 0);
    #4;
    reset = 1'b1;
    step(1);

    // Fire accepted neither while paused in IDLE nor after the pause ends.
    x_nave = 10'd100;
    applyStimulus(1, 0, 1);
    step(6);
    applyStimulus(0, 0, 1);
    step(3);
    applyStimulus(0, 0, 0);
    step(6);
    checkOutput("pause_idle_fire_lost", ativo, 0);

    // Restart in the same cycle as the fire edge keeps the block idle.
    applyStimulus(1, 0, 0);
    step(2);
    reiniciarJogo = 1'b1;
    disparo       = 1'b0;
    step(1);
    reiniciarJogo = 1'b0;
    checkOutput("restart_fire_idle", ativo, 0);
    step(6);
    checkOutput("restart_stays_idle", ativo, 0);

    // Score saturation: 255 hits reach 255, one more hit leaves it there.
    launch_misses = 0;
    pontos_at_255 = 8'd0;
    for (int i = 0; i < 256; i++) begin
      step(44);
      applyStimulus(1, 0, 0);
      n = 0;
      do begin
        step(1);
        n++;
      end while (!ativo && n < 4);
      if (!ativo) launch_misses++;
      applyStimulus(0, 0, 0);
      step(2);
      applyStimulus(0, 1, 0);
      step(1);
      applyStimulus(0, 0, 0);
      step(1);
      if (i == 254) pontos_at_255 = pontos;
    end
    checkOutput("sat_launch_misses", launch_misses, 0);
    checkOutput("sat_pontos_255", pontos_at_255, 255);
    checkOutput("sat_pontos_hold", pontos, 255);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
